// File: rtl/psg_write_arbiter.sv
// rtl/psg_write_arbiter.sv - two-requester round-robin write arbiter driving a PSG byte-wide write port
// Each granted command becomes one or two strobed bytes, and every READY edge wait is bounded by TIMEOUT.
module psg_write_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [1:0]  req,
    input  logic [5:0]  req_reg,
    input  logic [19:0] req_data,
    output logic [1:0]  grant,
    output logic        done,
    output logic        busy,
    output logic        timeout_err,
    output logic        nWE,
    output logic        nCE,
    output logic [7:0]  D,
    input  logic        READY
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

    state_t          state, state_n;
    logic            ready_m, ready_s;
    logic            last_win, last_win_n;
    logic            pend, pend_n;
    logic [5:0]      hi, hi_n;
    logic [CW-1:0]   wait_cnt, wait_cnt_n;
    logic            nwe_r, nwe_n;
    logic [7:0]      d_r, d_n;
    logic [1:0]      grant_r, grant_n;
    logic            done_r, done_n;
    logic            terr_r, terr_n;

    logic            win;
    logic [2:0]      sel_reg;
    logic [9:0]      sel_data;
    logic            wait_hit;

    // With both requesting, the one not served last wins; last_win resets to 1 so requester 0 is favoured.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10)
            win = 1'b1;
        else if (req == 2'b11)
            win = ~last_win;
    end

    assign sel_reg  = win ? req_reg[5:3]    : req_reg[2:0];
    assign sel_data = win ? req_data[19:10] : req_data[9:0];
    assign wait_hit = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state    <= IDLE;
            ready_m  <= 1'b1;
            ready_s  <= 1'b1;
            last_win <= 1'b1;
            pend     <= 1'b0;
            hi       <= 6'd0;
            wait_cnt <= '0;
            nwe_r    <= 1'b1;
            d_r      <= 8'h00;
            grant_r  <= 2'b00;
            done_r   <= 1'b0;
            terr_r   <= 1'b0;
        end else begin
            state    <= state_n;
            ready_m  <= READY;
            ready_s  <= ready_m;
            last_win <= last_win_n;
            pend     <= pend_n;
            hi       <= hi_n;
            wait_cnt <= wait_cnt_n;
            nwe_r    <= nwe_n;
            d_r      <= d_n;
            grant_r  <= grant_n;
            done_r   <= done_n;
            terr_r   <= terr_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req != 2'b00) state_n = SETUP;
            SETUP:   state_n = STROBE;
            STROBE:  if (!ready_s) state_n = RELEASE;
                     else if (wait_hit) state_n = IDLE;
            RELEASE: if (ready_s) state_n = pend ? SETUP : IDLE;
                     else if (wait_hit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // D is only reloaded on IDLE->SETUP and RELEASE->SETUP, both with the strobes high.
    always_comb begin
        nwe_n      = nwe_r;
        d_n        = d_r;
        grant_n    = 2'b00;
        done_n     = 1'b0;
        terr_n     = terr_r;
        pend_n     = pend;
        hi_n       = hi;
        last_win_n = last_win;
        wait_cnt_n = wait_cnt + 1'b1;
        case (state)
            IDLE: begin
                wait_cnt_n = '0;
                if (req != 2'b00) begin
                    grant_n    = win ? 2'b10 : 2'b01;
                    last_win_n = win;
                    d_n        = {1'b1, sel_reg, sel_data[3:0]};
                    pend_n     = !sel_reg[0] && (sel_reg[2:1] != 2'b11);
                    hi_n       = sel_data[9:4];
                end
            end
            SETUP: begin
                nwe_n      = 1'b0;
                wait_cnt_n = '0;
            end
            STROBE: begin
                if (!ready_s) begin
                    nwe_n      = 1'b1;
                    wait_cnt_n = '0;
                end else if (wait_hit) begin
                    nwe_n      = 1'b1;
                    terr_n     = 1'b1;
                    pend_n     = 1'b0;
                    wait_cnt_n = '0;
                end
            end
            RELEASE: begin
                if (ready_s) begin
                    wait_cnt_n = '0;
                    if (pend) begin
                        d_n    = {2'b00, hi};
                        pend_n = 1'b0;
                    end else begin
                        done_n = 1'b1;
                    end
                end else if (wait_hit) begin
                    terr_n     = 1'b1;
                    pend_n     = 1'b0;
                    wait_cnt_n = '0;
                end
            end
            default: wait_cnt_n = '0;
        endcase
    end

    assign busy        = (state != IDLE);
    assign nWE         = nwe_r;
    assign nCE         = nwe_r;
    assign D           = d_r;
    assign grant       = grant_r;
    assign done        = done_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_psg_write_arbiter.sv
// tb/tb_psg_write_arbiter.sv - scoreboard bench for psg_write_arbiter with a behavioural PSG READY model
module tb_psg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [5:0]  req_reg = 6'd0;
    logic [19:0] req_data = 20'd0;
    logic [1:0]  grant;
    logic        done, busy, timeout_err, nWE, nCE;
    logic [7:0]  D;
    logic        READY = 1'b1;

    psg_write_arbiter #(.TIMEOUT(16)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .req(req), .req_reg(req_reg),
        .req_data(req_data), .grant(grant), .done(done), .busy(busy),
        .timeout_err(timeout_err), .nWE(nWE), .nCE(nCE), .D(D), .READY(READY)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; logic [7:0] val;} ev_t;
    ev_t exp_q[$];
    int checks = 0;
    int failures = 0;
    logic stuck = 1'b0;
    logic prev_nwe = 1'b1;
    logic prev_terr = 1'b0;
    logic [7:0] held_d = 8'h00;
    int low_cnt = 0;
    int last_low = 0;

    task automatic expect_ev(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_ev(input int kind, input logic [7:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d val=%02h want=none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL event got kind=%0d val=%02h want kind=%0d val=%02h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Event kinds: 0 grant, 1 strobe byte, 2 done, 3 timeout_err rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (grant != 2'b00) check_ev(0, {6'd0, grant});
            if (prev_nwe && !nWE) begin
                check_ev(1, D);
                chk("nce_follows_nwe", nCE, 0);
                held_d  = D;
                low_cnt = 0;
            end
            if (!nWE && !prev_nwe) chk("d_stable_in_strobe", D, held_d);
            if (!nWE) low_cnt++;
            if (nWE && !prev_nwe) last_low = low_cnt;
            if (done) check_ev(2, 8'h00);
            if (timeout_err && !prev_terr) check_ev(3, 8'h00);
            prev_nwe  = nWE;
            prev_terr = timeout_err;
        end else begin
            prev_nwe  = 1'b1;
            prev_terr = 1'b0;
        end
    end

    // PSG model: READY drops one cycle after a strobe is seen and stays low for 5 cycles.
    initial begin
        forever begin
            @(posedge clk);
            if (!stuck && !nWE && rst_n) begin
                #1 READY = 1'b0;
                repeat (5) @(posedge clk);
                #1 READY = 1'b1;
                while (!nWE) @(posedge clk);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            failures++;
            $display("FAIL wait_idle busy=1 want=0 after %0d cycles", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] r);
        int n;
        n = 0;
        @(negedge clk);
        req = r;
        while (req != 2'b00 && n < 400) begin
            @(negedge clk);
            if (grant[0]) req[0] = 1'b0;
            if (grant[1]) req[1] = 1'b0;
            n++;
        end
        if (req != 2'b00) begin
            failures++;
            $display("FAIL grant_wait req=%b still pending want=00", req);
            req = 2'b00;
        end
        wait_idle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_nWE"}, nWE, 1);
        chk({tag, "_nCE"}, nCE, 1);
        chk({tag, "_D"}, D, 8'h00);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_terr"}, timeout_err, 0);
    endtask

    task automatic both_requesters();
        req_reg  = {3'b101, 3'b010};
        req_data = {10'h2C7, 10'h123};
        expect_ev(0, 8'h01); expect_ev(1, 8'hA3); expect_ev(1, 8'h12); expect_ev(2, 8'h00);
        expect_ev(0, 8'h02); expect_ev(1, 8'hD7); expect_ev(2, 8'h00);
        run_cmd(2'b11);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Volume write: one byte.
        req_reg = 6'b000_001; req_data = {10'h0, 10'h00A};
        expect_ev(0, 8'h01); expect_ev(1, 8'h9A); expect_ev(2, 8'h00);
        run_cmd(2'b01);

        // Tone write on requester 1: latch byte then data byte, one done.
        req_reg = {3'b000, 3'b000}; req_data = {10'h1FE, 10'h0};
        expect_ev(0, 8'h02); expect_ev(1, 8'h8E); expect_ev(1, 8'h1F); expect_ev(2, 8'h00);
        run_cmd(2'b10);

        both_requesters();

        // Noise register: type 0 but channel 3, so single byte.
        req_reg = {3'b000, 3'b110}; req_data = {10'h0, 10'h3F5};
        expect_ev(0, 8'h01); expect_ev(1, 8'hE5); expect_ev(2, 8'h00);
        run_cmd(2'b01);

        // READY stuck high: timeout after 16 strobe cycles, no done.
        stuck = 1'b1;
        req_reg = {3'b011, 3'b000}; req_data = {10'h055, 10'h0};
        expect_ev(0, 8'h02); expect_ev(1, 8'hB5); expect_ev(3, 8'h00);
        run_cmd(2'b10);
        chk("timeout_low_cycles", last_low, 16);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_busy", busy, 0);
        stuck = 1'b0;

        req_reg = 6'b000_001; req_data = {10'h0, 10'h00A};
        expect_ev(0, 8'h01); expect_ev(1, 8'h9A); expect_ev(2, 8'h00);
        run_cmd(2'b01);
        chk("timeout_err_sticky", timeout_err, 1);

        // Reset in the middle of a strobe.
        expect_ev(0, 8'h01); expect_ev(1, 8'h9A);
        @(negedge clk);
        req = 2'b01;
        for (int n = 0; n < 100 && nWE; n++) begin
            @(negedge clk);
            if (grant[0]) req = 2'b00;
        end
        chk("reached_strobe", nWE, 0);
        req = 2'b00;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        chk("midreset_events_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("after_reset_busy", busy, 0);

        both_requesters();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psg_write_arbiter.md
PSG_WRITE_ARBITER -- requirements
Module: psg_write_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, meaning: max CLK100MHZ cycles to wait for each READY edge.
REQ-002 CLK100MHZ  input  1  system clock; all state updates on its rising edge.
REQ-003 CPU_RESETN  input  1  reset; asynchronous, active-low.
REQ-004 req  input  2  per-requester write request; bit i = requester i.
REQ-005 req_reg  input  6  requester i register select at [3i+2:3i], encoded {channel[1:0], type}; type 0 = tone/noise, 1 = volume.
REQ-006 req_data  input  20  requester i value at [10i+9:10i].
REQ-007 grant  output  2  one-cycle pulse; bit i = requester i command captured.
REQ-008 done  output  1  one-cycle pulse when the last byte of a command completes.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 timeout_err  output  1  sticky; set on READY timeout, cleared only by reset.
REQ-011 nWE, nCE  output  1 each  PSG write strobes, active-low, driven identically.
REQ-012 D  output  8  PSG data bus.
REQ-013 READY  input  1  PSG ready; low while the chip is absorbing a write.

Function
REQ-014 READY SHALL pass through a 2-flop synchronizer (ready_s) before any use.
REQ-015 States SHALL be IDLE, SETUP, STROBE, RELEASE; nWE, nCE, D, grant and done SHALL be registered outputs.
REQ-016 In IDLE with any req bit high: capture the winner's req_reg/req_data, pulse its grant bit, load D with the latch byte, go to SETUP.
REQ-017 Arbitration SHALL be round-robin: single requester wins outright; with both high, the requester not granted last wins; pointer updates only on grant.
REQ-018 Latch byte SHALL be {1, reg[2:0], data[3:0]}.
REQ-019 Two-byte command when type = 0 and channel != 3; second byte SHALL be {2'b00, data[9:4]}; all others are one byte.
REQ-020 SETUP: strobes high, D held; after exactly one cycle go to STROBE, driving nWE = nCE = 0 from the next cycle.
REQ-021 STROBE: hold strobes low until ready_s = 0, then go to RELEASE, strobes = 1.
REQ-022 RELEASE: wait for ready_s = 1; if a second byte is pending, load D with it and go to SETUP; otherwise pulse done and go to IDLE.
REQ-023 D SHALL not change while nWE is low.
REQ-024 Requests arriving while busy SHALL be ignored until IDLE; a requester SHALL hold req until its grant, and req in the cycle of grant is not a new request.
REQ-025 The earliest a new grant can follow done is the cycle after the return to IDLE.
REQ-026 Wait counter SHALL clear on entering STROBE and RELEASE.
REQ-027 If the wait counter reaches TIMEOUT in STROBE or RELEASE: set timeout_err, drive strobes high, drop remaining bytes, pulse no done, go to IDLE.

Reset
REQ-028 While CPU_RESETN = 0: state = IDLE, nWE = nCE = 1, D = 8'h00, grant = 0, done = 0, busy = 0, timeout_err = 0, RR pointer favors requester 0, synchronizer flops = 1.
REQ-029 Reset mid-transfer SHALL abort immediately; the strobes go high asynchronously and no done is issued.

Verification
REQ-030 req = 01, reg0 = 3'b001, data0 = 10'h00A, chip model READY low 5 cycles after strobe -> grant = 01, one strobe with D = 8'h9A, done once.
REQ-031 req = 10, reg1 = 3'b000, data1 = 10'h1FE -> two strobes, D = 8'h8E then 8'h1F, single done after the second byte.
REQ-032 req = 11 held through two commands -> grants 01 then 10; repeat from reset -> same order; pointer alternates.
REQ-033 reg = 3'b110 (noise), data = 10'h3F5 -> one byte D = 8'hE5, no second byte.
REQ-034 READY stuck high, TIMEOUT = 16 -> strobes low 16 cycles then high, timeout_err = 1, busy = 0, no done; next request is serviced normally.
REQ-035 CPU_RESETN pulsed low during STROBE -> nWE = nCE = 1 at once, D = 8'h00, all outputs at reset values, no done.
